// File: rtl/expr_result_checker_if.sv
// Result/golden beat handshake between the expression block under test and expr_result_checker.
// Define EXPR_CHK_XMASK_EN to add the per-bit don't-care mask that travels with exp_y.
interface expr_result_checker_if;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_y;
  logic [89:0] exp_y;
`ifdef EXPR_CHK_XMASK_EN
  logic [89:0] exp_xmask;
`endif

  modport master (
`ifdef EXPR_CHK_XMASK_EN
    output exp_xmask,
`endif
    output in_valid,
    output in_y,
    output exp_y,
    input  in_ready
  );

  modport slave (
`ifdef EXPR_CHK_XMASK_EN
    input  exp_xmask,
`endif
    input  in_valid,
    input  in_y,
    input  exp_y,
    output in_ready
  );
endinterface

// File: rtl/expr_result_checker.sv
// Compares a stream of 90-bit results against golden vectors field by field and compresses them into a MISR.
// Optional feature macro: EXPR_CHK_XMASK_EN (bits set in exp_xmask are excluded from the comparison).
module expr_result_checker #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  expr_result_checker_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [17:0]          mismatch_mask,
  output logic                 first_err_valid,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [31:0]          signature,
  output logic [CNT_W-1:0]     sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_in_ready;

  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Stage 1: the accepted beat waits here one edge before it is scored.
  logic             r_s1_valid;
  logic [89:0]      r_s1_y;
  logic [89:0]      r_s1_exp;
  logic [CNT_W-1:0] r_s1_idx;
`ifdef EXPR_CHK_XMASK_EN
  logic [89:0]      r_s1_xmask;
`endif

  logic [17:0]      r_mask;
  logic             r_first_err_valid;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [31:0]      r_sig;

  logic [89:0]      w_diff;
  logic [17:0]      w_field_ne;
  logic [31:0]      w_sig_nxt;

  assign w_cnt_inc = r_sample_cnt + CNT_W'(1);
  assign w_accept  = bus.in_valid && w_in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_start_ok  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        busy       = 1'b1;
        if (bus.in_valid && (w_cnt_inc == r_num)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready = w_in_ready;

`ifdef EXPR_CHK_XMASK_EN
  assign w_diff = (r_s1_y ^ r_s1_exp) & ~r_s1_xmask;
`else
  assign w_diff = r_s1_y ^ r_s1_exp;
`endif

  // Field widths repeat 4,5,6; field k lands on mask bit 17-k.
  for (genvar k = 0; k < 18; k++) begin : g_field
    localparam int J  = k % 3;
    localparam int W  = 4 + J;
    localparam int HI = 89 - 15 * (k / 3) - ((J == 0) ? 0 : ((J == 1) ? 4 : 9));
    assign w_field_ne[17-k] = |w_diff[HI -: W];
  end

  assign w_sig_nxt = ({r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0))
                   ^ r_s1_y[31:0] ^ r_s1_y[63:32] ^ {6'b0, r_s1_y[89:64]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num             <= '0;
      r_sample_cnt      <= '0;
      r_s1_valid        <= 1'b0;
      r_s1_y            <= '0;
      r_s1_exp          <= '0;
      r_s1_idx          <= '0;
`ifdef EXPR_CHK_XMASK_EN
      r_s1_xmask        <= '0;
`endif
      r_mask            <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_sig             <= SEED;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_y       <= bus.in_y;
        r_s1_exp     <= bus.exp_y;
`ifdef EXPR_CHK_XMASK_EN
        r_s1_xmask   <= bus.exp_xmask;
`endif
        r_s1_idx     <= r_sample_cnt;
        r_sample_cnt <= w_cnt_inc;
      end
      // start is only honoured in IDLE/DONE, where stage 1 is always empty.
      if (w_start_ok) begin
        r_num             <= num_samples;
        r_sample_cnt      <= '0;
        r_mask            <= '0;
        r_first_err_valid <= 1'b0;
        r_first_err_idx   <= '0;
        r_sig             <= SEED;
      end else if (r_s1_valid) begin
        r_mask <= r_mask | w_field_ne;
        r_sig  <= w_sig_nxt;
        if (!r_first_err_valid && (|w_field_ne)) begin
          r_first_err_valid <= 1'b1;
          r_first_err_idx   <= r_s1_idx;
        end
      end
    end
  end

  assign pass            = done && (r_mask == '0);
  assign mismatch_mask   = r_mask;
  assign first_err_valid = r_first_err_valid;
  assign first_err_idx   = r_first_err_idx;
  assign signature       = r_sig;
  assign sample_cnt      = r_sample_cnt;

endmodule
